// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: DEPTH-stage register pipeline for decoded control words
// between decode and execute. Each stage holds {valid, ctrl, ds}. Supports
// stall (hold everything) and flush (bubble every stage). Tracks pending
// transfer-of-control instructions so that the following instruction gets
// tagged as a delay slot. A saturating counter records stall cycles.
module ctrl_pipe_stage #(
    parameter int CTRL_W        = 22,
    parameter int TA_BIT        = 7,
    parameter int DEPTH         = 1,
    parameter int FLUSH_KEEP_DS = 1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              stall,
    input  logic              flush,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              ds_out,
    output logic              ta_pending,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              valid_q [DEPTH];
    logic              valid_d [DEPTH];
    logic [CTRL_W-1:0] ctrl_q  [DEPTH];
    logic [CTRL_W-1:0] ctrl_d  [DEPTH];
    logic              ds_q    [DEPTH];
    logic              ds_d    [DEPTH];
    logic              ta_q;
    logic              ta_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              ds_new;
    logic              keep_ds;

    // Next-state for the stage registers, TA tracking and the stall counter.
    // Flush outranks stall; the stall counter only advances on pure stalls.
    // ctrl/ds are zeroed at the register input whenever valid is 0 so the
    // outputs can be taken straight from the last stage.
    always_comb begin
        ds_new  = ta_q && valid_in;
        keep_ds = (FLUSH_KEEP_DS != 0) && ta_q && valid_in;
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        ds_d    = ds_q;
        ta_d    = ta_q;
        cnt_d   = cnt_q;
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_d[i] = 1'b0;
                ctrl_d[i]  = '0;
                ds_d[i]    = 1'b0;
            end
            ta_d = 1'b0;
            if (keep_ds) begin
                // delay slot of an accepted TA survives the flush in stage 0
                valid_d[0] = 1'b1;
                ctrl_d[0]  = ctrl_in;
                ds_d[0]    = 1'b1;
                ta_d       = ctrl_in[TA_BIT];
            end
        end else if (stall) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            valid_d[0] = valid_in;
            ctrl_d[0]  = valid_in ? ctrl_in : '0;
            ds_d[0]    = ds_new;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                ctrl_d[i]  = ctrl_q[i-1];
                ds_d[i]    = ds_q[i-1];
            end
            if (valid_in) begin
                ta_d = ctrl_in[TA_BIT];
            end
        end
    end

    // State registers with synchronous reset overriding stall and flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '{default: 1'b0};
            ctrl_q  <= '{default: '0};
            ds_q    <= '{default: 1'b0};
            ta_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            ds_q    <= ds_d;
            ta_q    <= ta_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_out  = valid_q[DEPTH-1];
    assign ctrl_out   = ctrl_q[DEPTH-1];
    assign ds_out     = ds_q[DEPTH-1];
    assign ta_pending = ta_q;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// tb_ctrl_pipe_stage: four parameterisations of ctrl_pipe_stage share one
// input stream. A queue-based model of each instance is checked every cycle;
// a vector table and hand-written sequences cover the specific corner cases.
module tb_ctrl_pipe_stage;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [21:0] ctrl_in;
    logic        stall;
    logic        flush;

    logic        vo  [4];
    logic [21:0] co  [4];
    logic        dso [4];
    logic        tpo [4];
    logic [15:0] sco [4];
    logic [3:0]  sc4;

    int n_chk;
    int n_err;

    // Instance 0: DEPTH=1 keep; 1: DEPTH=3 keep; 2: DEPTH=3 drop; 3: DEPTH=2 drop, CNT_W=4
    ctrl_pipe_stage #(.CTRL_W(22), .TA_BIT(7), .DEPTH(1), .FLUSH_KEEP_DS(1), .CNT_W(16)) u_d1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ctrl_in(ctrl_in), .stall(stall),
        .flush(flush), .valid_out(vo[0]), .ctrl_out(co[0]), .ds_out(dso[0]),
        .ta_pending(tpo[0]), .stall_cnt(sco[0]));
    ctrl_pipe_stage #(.CTRL_W(22), .TA_BIT(7), .DEPTH(3), .FLUSH_KEEP_DS(1), .CNT_W(16)) u_d3k (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ctrl_in(ctrl_in), .stall(stall),
        .flush(flush), .valid_out(vo[1]), .ctrl_out(co[1]), .ds_out(dso[1]),
        .ta_pending(tpo[1]), .stall_cnt(sco[1]));
    ctrl_pipe_stage #(.CTRL_W(22), .TA_BIT(7), .DEPTH(3), .FLUSH_KEEP_DS(0), .CNT_W(16)) u_d3n (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ctrl_in(ctrl_in), .stall(stall),
        .flush(flush), .valid_out(vo[2]), .ctrl_out(co[2]), .ds_out(dso[2]),
        .ta_pending(tpo[2]), .stall_cnt(sco[2]));
    ctrl_pipe_stage #(.CTRL_W(22), .TA_BIT(7), .DEPTH(2), .FLUSH_KEEP_DS(0), .CNT_W(4)) u_c4 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ctrl_in(ctrl_in), .stall(stall),
        .flush(flush), .valid_out(vo[3]), .ctrl_out(co[3]), .ds_out(dso[3]),
        .ta_pending(tpo[3]), .stall_cnt(sc4));
    assign sco[3] = {12'h000, sc4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic        v;
        logic [21:0] c;
        logic        d;
    } ent_t;

    ent_t mq [4][$];
    logic mta [4];
    int   mcnt [4];
    int   dep  [4] = '{1, 3, 3, 2};
    int   keep [4] = '{1, 1, 0, 0};
    int   cntw [4] = '{16, 16, 16, 4};

    function automatic void model_clear(int k);
        ent_t b;
        b.v = 1'b0; b.c = '0; b.d = 1'b0;
        mq[k].delete();
        repeat (dep[k]) mq[k].push_back(b);
    endfunction

    function automatic void model_step(int k);
        ent_t e;
        int   mx;
        logic kept;
        mx = (1 << cntw[k]) - 1;
        if (reset) begin
            model_clear(k);
            mta[k]  = 1'b0;
            mcnt[k] = 0;
        end else if (flush) begin
            kept = (keep[k] != 0) && mta[k] && valid_in;
            model_clear(k);
            if (kept) begin
                e.v = 1'b1; e.c = ctrl_in; e.d = 1'b1;
                mq[k][0] = e;
            end
            mta[k] = kept && ctrl_in[7];
        end else if (stall) begin
            if (mcnt[k] < mx) mcnt[k] = mcnt[k] + 1;
        end else begin
            e.v = valid_in;
            e.c = valid_in ? ctrl_in : 22'h0;
            e.d = mta[k] && valid_in;
            mq[k].push_front(e);
            void'(mq[k].pop_back());
            if (valid_in) mta[k] = ctrl_in[7];
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_check();
        ent_t o;
        for (int k = 0; k < 4; k++) begin
            o = mq[k][dep[k]-1];
            chk($sformatf("u%0d.valid", k), 32'(vo[k]),  32'(o.v));
            chk($sformatf("u%0d.ctrl", k),  32'(co[k]),  32'(o.c));
            chk($sformatf("u%0d.ds", k),    32'(dso[k]), 32'(o.d));
            chk($sformatf("u%0d.ta", k),    32'(tpo[k]), 32'(mta[k]));
            chk($sformatf("u%0d.cnt", k),   32'(sco[k]), 32'(mcnt[k]));
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [21:0] c,
                       input logic s, input logic f);
        reset = r; valid_in = v; ctrl_in = c; stall = s; flush = f;
        @(posedge clk);
        for (int k = 0; k < 4; k++) model_step(k);
        #1;
        model_check();
    endtask

    // ---------------- vector table for the DEPTH=1 instance ----------------
    typedef struct {
        logic        rst;
        logic        vin;
        logic [21:0] c;
        logic        st;
        logic        fl;
        logic        ev;
        logic [21:0] ec;
        logic        ed;
        logic        eta;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [17];

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1; valid_in = 1'b0; ctrl_in = '0; stall = 1'b0; flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            model_clear(k);
            mta[k] = 1'b0;
            mcnt[k] = 0;
        end

        //          rst  vin  ctrl        st   fl    ev   ectrl       ed   eta  ecnt
        tbl[0]  = '{1'b1,1'b0,22'h000000,1'b0,1'b0, 1'b0,22'h000000,1'b0,1'b0,16'd0};
        tbl[1]  = '{1'b0,1'b1,22'h000080,1'b0,1'b0, 1'b1,22'h000080,1'b0,1'b1,16'd0};
        tbl[2]  = '{1'b0,1'b1,22'h000011,1'b0,1'b0, 1'b1,22'h000011,1'b1,1'b0,16'd0};
        tbl[3]  = '{1'b0,1'b1,22'h000080,1'b0,1'b0, 1'b1,22'h000080,1'b0,1'b1,16'd0};
        tbl[4]  = '{1'b0,1'b0,22'h000000,1'b0,1'b0, 1'b0,22'h000000,1'b0,1'b1,16'd0};
        tbl[5]  = '{1'b0,1'b1,22'h000011,1'b0,1'b0, 1'b1,22'h000011,1'b1,1'b0,16'd0};
        tbl[6]  = '{1'b0,1'b1,22'h000080,1'b0,1'b0, 1'b1,22'h000080,1'b0,1'b1,16'd0};
        tbl[7]  = '{1'b0,1'b1,22'h000080,1'b0,1'b0, 1'b1,22'h000080,1'b1,1'b1,16'd0};
        tbl[8]  = '{1'b0,1'b1,22'h000005,1'b0,1'b0, 1'b1,22'h000005,1'b1,1'b0,16'd0};
        tbl[9]  = '{1'b0,1'b1,22'h3FFFFF,1'b1,1'b0, 1'b1,22'h000005,1'b1,1'b0,16'd1};
        tbl[10] = '{1'b0,1'b1,22'h000022,1'b1,1'b1, 1'b0,22'h000000,1'b0,1'b0,16'd1};
        tbl[11] = '{1'b0,1'b1,22'h000080,1'b0,1'b0, 1'b1,22'h000080,1'b0,1'b1,16'd1};
        tbl[12] = '{1'b0,1'b1,22'h0002A5,1'b0,1'b1, 1'b1,22'h0002A5,1'b1,1'b1,16'd1};
        tbl[13] = '{1'b0,1'b1,22'h000003,1'b0,1'b1, 1'b1,22'h000003,1'b1,1'b0,16'd1};
        tbl[14] = '{1'b0,1'b1,22'h000080,1'b0,1'b1, 1'b0,22'h000000,1'b0,1'b0,16'd1};
        tbl[15] = '{1'b0,1'b0,22'h001234,1'b0,1'b0, 1'b0,22'h000000,1'b0,1'b0,16'd1};
        tbl[16] = '{1'b1,1'b0,22'h000000,1'b1,1'b0, 1'b0,22'h000000,1'b0,1'b0,16'd0};

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].rst, tbl[i].vin, tbl[i].c, tbl[i].st, tbl[i].fl);
            chk($sformatf("tbl%0d.valid", i), 32'(vo[0]),  32'(tbl[i].ev));
            chk($sformatf("tbl%0d.ctrl", i),  32'(co[0]),  32'(tbl[i].ec));
            chk($sformatf("tbl%0d.ds", i),    32'(dso[0]), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d.ta", i),    32'(tpo[0]), 32'(tbl[i].eta));
            chk($sformatf("tbl%0d.cnt", i),   32'(sco[0]), 32'(tbl[i].ecnt));
        end

        // DEPTH=3 stream with a 2-cycle stall after B
        cyc(1'b1, 1'b0, 22'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 22'h000A01, 1'b0, 1'b0);
        chk("stall.a_e1_v", 32'(vo[1]), 32'h0);
        cyc(1'b0, 1'b1, 22'h001B02, 1'b0, 1'b0);
        chk("stall.a_e2_v", 32'(vo[1]), 32'h0);
        cyc(1'b0, 1'b1, 22'h002C03, 1'b1, 1'b0);
        chk("stall.hold1_v", 32'(vo[1]), 32'h0);
        cyc(1'b0, 1'b1, 22'h002C03, 1'b1, 1'b0);
        chk("stall.hold2_v", 32'(vo[1]), 32'h0);
        chk("stall.cnt2", 32'(sco[1]), 32'd2);
        cyc(1'b0, 1'b1, 22'h002C03, 1'b0, 1'b0);
        chk("stall.a_out_v", 32'(vo[1]), 32'h1);
        chk("stall.a_out_c", 32'(co[1]), 32'h000A01);
        cyc(1'b0, 1'b0, 22'h0, 1'b0, 1'b0);
        chk("stall.b_out_c", 32'(co[1]), 32'h001B02);
        cyc(1'b0, 1'b0, 22'h0, 1'b0, 1'b0);
        chk("stall.c_out_c", 32'(co[1]), 32'h002C03);

        // flush with all three stages valid and stall high
        cyc(1'b0, 1'b1, 22'h000D04, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 22'h000E85, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 22'h000F06, 1'b0, 1'b0);
        chk("flush.pre_v", 32'(vo[1]), 32'h1);
        cyc(1'b0, 1'b1, 22'h000107, 1'b1, 1'b1);
        chk("flush.v", 32'(vo[1]), 32'h0);
        chk("flush.c", 32'(co[1]), 32'h0);
        chk("flush.ta", 32'(tpo[1]), 32'h0);
        chk("flush.cnt", 32'(sco[1]), 32'd2);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 22'h0, 1'b0, 1'b0);
            chk($sformatf("flush.drain%0d_v", i), 32'(vo[1]), 32'h0);
        end

        // flush arriving with the delay slot of an accepted TA
        cyc(1'b1, 1'b0, 22'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 22'h000080, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 22'h000011, 1'b0, 1'b1);
        chk("keep.d1_v", 32'(vo[0]), 32'h1);
        chk("keep.d1_c", 32'(co[0]), 32'h000011);
        chk("keep.d1_ds", 32'(dso[0]), 32'h1);
        chk("keep.d3_v0", 32'(vo[1]), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 22'h0, 1'b0, 1'b0);
            chk($sformatf("drop.d3n_v%0d", i), 32'(vo[2]), 32'h0);
            chk($sformatf("drop.d2n_v%0d", i), 32'(vo[3]), 32'h0);
            chk($sformatf("keep.d3_v%0d", i), 32'(vo[1]), (i == 1) ? 32'h1 : 32'h0);
            if (i == 1) begin
                chk("keep.d3_c", 32'(co[1]), 32'h000011);
                chk("keep.d3_ds", 32'(dso[1]), 32'h1);
            end
        end

        // saturating 4-bit counter, then reset during stall
        cyc(1'b1, 1'b0, 22'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 22'h000055, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 22'h000066, 1'b1, 1'b0);
        chk("sat.cnt4", 32'(sco[3]), 32'hF);
        chk("sat.cnt16", 32'(sco[0]), 32'd20);
        cyc(1'b1, 1'b1, 22'h000066, 1'b1, 1'b0);
        chk("sat.rst_cnt", 32'(sco[3]), 32'h0);
        chk("sat.rst_v", 32'(vo[3]), 32'h0);
        chk("sat.rst_c", 32'(co[3]), 32'h0);
        chk("sat.rst_v1", 32'(vo[0]), 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [21:0] c;
            c = 22'($urandom);
            c[7] = ($urandom_range(0, 9) < 4);
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), c,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
